// File: rtl/pc_pkg.sv
// Shared types and default vectors for the fetch-stage next-PC logic.
package pc_pkg;

  typedef enum logic [2:0] {
    SEQ  = 3'd0,
    HOLD = 3'd1,
    BR   = 3'd2,
    J    = 3'd3,
    JR   = 3'd4,
    IRQ  = 3'd5,
    EXC  = 3'd6
  } pc_src_t;

  localparam logic [31:0] RESET_PC  = 32'h8000_0000;
  localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] XADR_VEC  = 32'h8000_0008;

  // Any source other than sequential fetch or hold invalidates IF/ID.
  function automatic logic is_redirect(input pc_src_t src);
    return !((src == SEQ) || (src == HOLD));
  endfunction

  // EPC is captured only when control transfers to a trap vector.
  function automatic logic is_trap(input pc_src_t src);
    return (src == EXC) || (src == IRQ);
  endfunction

endpackage

// File: rtl/pc_redirect_sel.sv
// Combinational priority encoder choosing the next fetch PC and its source.
module pc_redirect_sel
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] ILLOP_VEC = XLEN'(pc_pkg::ILLOP_VEC),
  parameter logic [XLEN-1:0] XADR_VEC  = XLEN'(pc_pkg::XADR_VEC)
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic            exc,
  input  logic            irq_take,
  input  logic            stall,
  input  logic            jr_valid,
  input  logic [XLEN-1:0] jr_target,
  input  logic            j_valid,
  input  logic [25:0]     j_index,
  input  logic            br_valid,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  output pc_src_t         src,
  output logic [XLEN-1:0] nxt
);

  logic [XLEN-1:0] j_target;

  // Jump keeps the region bits of the delay-slot address, as in MIPS.
  assign j_target = {pc_plus4[XLEN-1:28], j_index, 2'b00};

  always_comb begin
    src = SEQ;
    nxt = pc_plus4;
    if (exc) begin
      src = EXC;
      nxt = XADR_VEC;
    end else if (irq_take) begin
      src = IRQ;
      nxt = ILLOP_VEC;
    end else if (stall) begin
      src = HOLD;
      nxt = pc;
    end else if (jr_valid) begin
      src = JR;
      nxt = jr_target;
    end else if (j_valid) begin
      src = J;
      nxt = j_target;
    end else if (br_valid && br_taken) begin
      src = BR;
      nxt = br_target;
    end
  end

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter register with prioritised redirect, stall hold, masked
// interrupt latch and registered flush / acknowledge / EPC outputs.
module pc_next_unit
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(pc_pkg::RESET_PC),
  parameter logic [XLEN-1:0] ILLOP_VEC = XLEN'(pc_pkg::ILLOP_VEC),
  parameter logic [XLEN-1:0] XADR_VEC  = XLEN'(pc_pkg::XADR_VEC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            br_valid_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic            j_valid_i,
  input  logic [25:0]     j_index_i,
  input  logic            jr_valid_i,
  input  logic [XLEN-1:0] jr_target_i,
  input  logic            irq_i,
  input  logic            exc_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            flush_o,
  output logic            irq_ack_o,
  output logic [XLEN-1:0] epc_o
);

  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] epc_reg;
  logic [XLEN-1:0] epc_next;
  logic [XLEN-1:0] pc_plus4;
  logic            flush_reg;
  logic            flush_next;
  logic            irq_ack_reg;
  logic            irq_ack_next;
  logic            irq_pend_reg;
  logic            irq_pend_next;
  logic            kernel;
  logic            irq_take;
  pc_src_t         src;

  assign kernel   = pc_reg[XLEN-1];
  assign pc_plus4 = pc_reg + XLEN'(4);

  // Defer the interrupt behind any in-flight redirect so its target is not
  // overwritten and the EPC always names the next unfetched instruction.
  assign irq_take = irq_pend_reg & ~kernel & ~stall_i & ~br_valid_i &
                    ~j_valid_i & ~jr_valid_i & ~exc_i;

  pc_redirect_sel #(
    .XLEN      (XLEN),
    .ILLOP_VEC (ILLOP_VEC),
    .XADR_VEC  (XADR_VEC)
  ) u_sel (
    .pc        (pc_reg),
    .pc_plus4  (pc_plus4),
    .exc       (exc_i),
    .irq_take  (irq_take),
    .stall     (stall_i),
    .jr_valid  (jr_valid_i),
    .jr_target (jr_target_i),
    .j_valid   (j_valid_i),
    .j_index   (j_index_i),
    .br_valid  (br_valid_i),
    .br_taken  (br_taken_i),
    .br_target (br_target_i),
    .src       (src),
    .nxt       (pc_next)
  );

  always_comb begin
    flush_next    = is_redirect(src);
    irq_ack_next  = irq_take;
    irq_pend_next = (irq_pend_reg | irq_i) & ~irq_take;
    epc_next      = epc_reg;
    if (is_trap(src)) begin
      epc_next = pc_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg       <= RESET_PC;
      epc_reg      <= '0;
      flush_reg    <= 1'b0;
      irq_ack_reg  <= 1'b0;
      irq_pend_reg <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      epc_reg      <= epc_next;
      flush_reg    <= flush_next;
      irq_ack_reg  <= irq_ack_next;
      irq_pend_reg <= irq_pend_next;
    end
  end

  assign pc_o       = pc_reg;
  assign pc_plus4_o = pc_plus4;
  assign flush_o    = flush_reg;
  assign irq_ack_o  = irq_ack_reg;
  assign epc_o      = epc_reg;

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed scenarios plus random
// traffic compared against a cycle-level behavioural model.
module tb_pc_next_unit;

  localparam int XLEN = 32;
  localparam logic [31:0] R_PC  = 32'h8000_0000;
  localparam logic [31:0] I_VEC = 32'h8000_0004;
  localparam logic [31:0] X_VEC = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_i = 1'b0;
  logic        br_valid_i = 1'b0;
  logic        br_taken_i = 1'b0;
  logic [31:0] br_target_i = '0;
  logic        j_valid_i = 1'b0;
  logic [25:0] j_index_i = '0;
  logic        jr_valid_i = 1'b0;
  logic [31:0] jr_target_i = '0;
  logic        irq_i = 1'b0;
  logic        exc_i = 1'b0;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        flush_o;
  logic        irq_ack_o;
  logic [31:0] epc_o;

  int checks = 0;
  int errors = 0;
  int cycle_no = 0;

  // Reference model state
  logic [31:0] m_pc = R_PC;
  logic [31:0] m_epc = '0;
  logic        m_flush = 1'b0;
  logic        m_ack = 1'b0;
  logic        m_pend = 1'b0;

  always #5 clk = ~clk;

  pc_next_unit #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall_i     (stall_i),
    .br_valid_i  (br_valid_i),
    .br_taken_i  (br_taken_i),
    .br_target_i (br_target_i),
    .j_valid_i   (j_valid_i),
    .j_index_i   (j_index_i),
    .jr_valid_i  (jr_valid_i),
    .jr_target_i (jr_target_i),
    .irq_i       (irq_i),
    .exc_i       (exc_i),
    .pc_o        (pc_o),
    .pc_plus4_o  (pc_plus4_o),
    .flush_o     (flush_o),
    .irq_ack_o   (irq_ack_o),
    .epc_o       (epc_o)
  );

  // One clock of architectural behaviour, from the currently driven inputs.
  task automatic model_update();
    logic [31:0] seq;
    logic [31:0] target;
    logic        take;
    logic        redirect;
    if (reset) begin
      m_pc = R_PC; m_epc = '0; m_flush = 1'b0; m_ack = 1'b0; m_pend = 1'b0;
    end else begin
      seq = m_pc + 32'd4;
      take = m_pend && !m_pc[31] && !stall_i && !br_valid_i && !j_valid_i &&
             !jr_valid_i && !exc_i;
      redirect = 1'b1;
      target = seq;
      if (exc_i) begin
        target = X_VEC; m_epc = m_pc;
      end else if (take) begin
        target = I_VEC; m_epc = m_pc;
      end else if (stall_i) begin
        target = m_pc; redirect = 1'b0;
      end else if (jr_valid_i) begin
        target = jr_target_i;
      end else if (j_valid_i) begin
        target = {seq[31:28], j_index_i, 2'b00};
      end else if (br_valid_i && br_taken_i) begin
        target = br_target_i;
      end else begin
        redirect = 1'b0;
      end
      m_pend = (m_pend || irq_i) && !take;
      m_flush = redirect;
      m_ack = take;
      m_pc = target;
    end
  endtask

  task automatic clear_inputs();
    stall_i = 0; br_valid_i = 0; br_taken_i = 0; br_target_i = '0;
    j_valid_i = 0; j_index_i = '0; jr_valid_i = 0; jr_target_i = '0;
    irq_i = 0; exc_i = 0;
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    cycle_no++;
    $display("cycle %0d pc=%h flush=%b ack=%b epc=%h", cycle_no, pc_o, flush_o, irq_ack_o, epc_o);
  endtask

  task automatic jump_to(input logic [31:0] addr);
    clear_inputs(); jr_valid_i = 1; jr_target_i = addr;
    step();
    clear_inputs();
  endtask

  task automatic test_reset();
    reset = 1; clear_inputs();
    step(); step();
    reset = 0;
    checks++; if (pc_o !== R_PC) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc_o, R_PC); end
    checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b expected 0", flush_o); end
    checks++; if (irq_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", irq_ack_o); end
    checks++; if (epc_o !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h expected 0", epc_o); end
    step();
    checks++; if (pc_o !== 32'h8000_0004) begin errors++; $display("FAIL seq1_pc: got %h expected 80000004", pc_o); end
    step();
    checks++; if (pc_o !== 32'h8000_0008 || flush_o !== 1'b0) begin errors++; $display("FAIL seq2_pc: got %h/%b expected 80000008/0", pc_o, flush_o); end
  endtask

  task automatic test_branch();
    jump_to(32'h0040_0010);
    checks++; if (pc_o !== 32'h0040_0010 || flush_o !== 1'b1) begin errors++; $display("FAIL jr_setup: got %h/%b expected 00400010/1", pc_o, flush_o); end
    br_valid_i = 1; br_taken_i = 1; br_target_i = 32'h0040_0100;
    step(); clear_inputs();
    checks++; if (pc_o !== 32'h0040_0100 || flush_o !== 1'b1) begin errors++; $display("FAIL br_taken: got %h/%b expected 00400100/1", pc_o, flush_o); end
    jump_to(32'h0040_0010);
    br_valid_i = 1; br_taken_i = 0; br_target_i = 32'h0040_0100;
    step(); clear_inputs();
    checks++; if (pc_o !== 32'h0040_0014 || flush_o !== 1'b0) begin errors++; $display("FAIL br_not_taken: got %h/%b expected 00400014/0", pc_o, flush_o); end
  endtask

  task automatic test_priority();
    jr_valid_i = 1; jr_target_i = 32'h0040_0200;
    j_valid_i = 1; j_index_i = 26'h000_0080;
    br_valid_i = 1; br_taken_i = 1; br_target_i = 32'h0040_0100;
    step();
    checks++; if (pc_o !== 32'h0040_0200 || flush_o !== 1'b1) begin errors++; $display("FAIL prio_jr: got %h/%b expected 00400200/1", pc_o, flush_o); end
    exc_i = 1;
    step(); clear_inputs();
    checks++; if (pc_o !== X_VEC) begin errors++; $display("FAIL prio_exc_pc: got %h expected %h", pc_o, X_VEC); end
    checks++; if (epc_o !== 32'h0040_0200) begin errors++; $display("FAIL prio_exc_epc: got %h expected 00400200", epc_o); end
    j_valid_i = 1; j_index_i = 26'h000_0080;
    step(); clear_inputs();
    checks++; if (pc_o !== 32'h8000_0200) begin errors++; $display("FAIL j_target: got %h expected 80000200", pc_o); end
  endtask

  task automatic test_irq_stall();
    jump_to(32'h0040_0020);
    stall_i = 1; irq_i = 1;
    step();
    irq_i = 0;
    step();
    checks++; if (pc_o !== 32'h0040_0020 || irq_ack_o !== 1'b0) begin errors++; $display("FAIL irq_stall_hold: got %h/%b expected 00400020/0", pc_o, irq_ack_o); end
    stall_i = 0;
    step();
    checks++; if (pc_o !== I_VEC || irq_ack_o !== 1'b1 || flush_o !== 1'b1) begin errors++; $display("FAIL irq_take: got %h/%b/%b expected %h/1/1", pc_o, irq_ack_o, flush_o, I_VEC); end
    checks++; if (epc_o !== 32'h0040_0020) begin errors++; $display("FAIL irq_epc: got %h expected 00400020", epc_o); end
    step();
    checks++; if (irq_ack_o !== 1'b0 || flush_o !== 1'b0) begin errors++; $display("FAIL irq_pulse: got ack=%b flush=%b expected 0/0", irq_ack_o, flush_o); end
  endtask

  task automatic test_kernel_mask();
    jump_to(32'h8000_0040);
    irq_i = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (irq_ack_o !== 1'b0 || pc_o !== 32'h8000_0044 + 32'(4 * i)) begin errors++; $display("FAIL kernel_mask: got %h/%b expected %h/0", pc_o, irq_ack_o, 32'h8000_0044 + 32'(4 * i)); end
    end
    irq_i = 0;
    jump_to(32'h0040_0000);
    checks++; if (pc_o !== 32'h0040_0000 || irq_ack_o !== 1'b0) begin errors++; $display("FAIL mask_jr: got %h/%b expected 00400000/0", pc_o, irq_ack_o); end
    step();
    checks++; if (pc_o !== I_VEC || irq_ack_o !== 1'b1 || epc_o !== 32'h0040_0000) begin errors++; $display("FAIL pend_take: got %h/%b/%h expected %h/1/00400000", pc_o, irq_ack_o, epc_o, I_VEC); end
  endtask

  task automatic test_wrap_and_reset();
    jump_to(32'hFFFF_FFFC);
    checks++; if (pc_plus4_o !== 32'h0) begin errors++; $display("FAIL plus4_wrap: got %h expected 00000000", pc_plus4_o); end
    step();
    checks++; if (pc_o !== 32'h0 || flush_o !== 1'b0) begin errors++; $display("FAIL pc_wrap: got %h/%b expected 00000000/0", pc_o, flush_o); end
    jr_valid_i = 1; jr_target_i = 32'h0040_0300; exc_i = 1; reset = 1;
    step();
    reset = 0; clear_inputs();
    checks++; if (pc_o !== R_PC || flush_o !== 1'b0 || epc_o !== 32'h0) begin errors++; $display("FAIL reset_mid: got %h/%b/%h expected %h/0/0", pc_o, flush_o, epc_o, R_PC); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      jr_valid_i = 1; jr_target_i = 32'h0041_0000 + 32'(i * 16);
      step();
      checks++; if (flush_o !== 1'b1 || pc_o !== jr_target_i) begin errors++; $display("FAIL b2b_flush: got %h/%b expected %h/1", pc_o, flush_o, jr_target_i); end
    end
    stall_i = 1; jr_valid_i = 1; jr_target_i = 32'h0050_0000;
    step(); clear_inputs();
    checks++; if (pc_o !== 32'h0041_0020 || flush_o !== 1'b0) begin errors++; $display("FAIL stall_drop: got %h/%b expected 00410020/0", pc_o, flush_o); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      stall_i     = ($urandom_range(99) < 20);
      br_valid_i  = ($urandom_range(99) < 20);
      br_taken_i  = $urandom_range(1) == 1;
      br_target_i = $urandom;
      j_valid_i   = ($urandom_range(99) < 10);
      j_index_i   = 26'($urandom);
      jr_valid_i  = ($urandom_range(99) < 10);
      jr_target_i = $urandom_range(1) == 1 ? ($urandom & 32'h7FFF_FFFC) : $urandom;
      irq_i       = ($urandom_range(99) < 10);
      exc_i       = ($urandom_range(99) < 3);
      reset       = ($urandom_range(99) < 1);
      step();
      checks++;
      if (pc_o !== m_pc || pc_plus4_o !== m_pc + 32'd4 || flush_o !== m_flush ||
          irq_ack_o !== m_ack || epc_o !== m_epc) begin
        errors++;
        $display("FAIL random_%0d: got pc=%h p4=%h fl=%b ack=%b epc=%h expected pc=%h fl=%b ack=%b epc=%h",
                 n, pc_o, pc_plus4_o, flush_o, irq_ack_o, epc_o, m_pc, m_flush, m_ack, m_epc);
      end
    end
    reset = 0; clear_inputs();
  endtask

  initial begin
    test_reset();
    test_branch();
    test_priority();
    test_irq_stall();
    test_kernel_mask();
    test_wrap_and_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Parametrised successor to the fetch-stage PC-next selector. It owns the program-counter register and picks the next PC by priority: sequential, taken branch, jump, register jump, interrupt or exception. It adds stall hold, a pending-interrupt latch with kernel-mode masking, and registered flush, acknowledge and EPC outputs. It sits at the head of the IF stage and feeds the instruction memory address and IF/ID `pc_plus4`.

## Interface
Parameters:
- `XLEN`, 32: PC/data width (≥ 32).
- `RESET_PC`, 32'h8000_0000: PC after reset (kernel space).
- `ILLOP_VEC`, 32'h8000_0004: interrupt entry.
- `XADR_VEC`, 32'h8000_0008: exception entry.

Ports:
- `clk`  in  1  clock; single clock domain, all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `stall_i`  in  1  hold PC (load-use / memory stall).
- `br_valid_i`  in  1  conditional branch resolved this cycle.
- `br_taken_i`  in  1  branch condition result (ALU zero/compare).
- `br_target_i`  in  XLEN  branch target (ConBA).
- `j_valid_i`  in  1  J/JAL in decode.
- `j_index_i`  in  26  instruction index field.
- `jr_valid_i`  in  1  JR/JALR in decode.
- `jr_target_i`  in  XLEN  rs value.
- `irq_i`  in  1  external interrupt, level.
- `exc_i`  in  1  undefined-instruction exception, single-cycle pulse.
- `pc_o`  out  XLEN  current fetch PC.
- `pc_plus4_o`  out  XLEN  `pc_o + 4`, combinational.
- `flush_o`  out  1  one-cycle pulse: IF/ID contents invalid.
- `irq_ack_o`  out  1  one-cycle pulse: interrupt taken.
- `epc_o`  out  XLEN  return address captured on interrupt or exception.

## Operation
- `kernel = pc_o[XLEN-1]`.
- `irq_pend` register: `irq_pend_next = (irq_pend | irq_i) & ~irq_take`. The take clears it even if `irq_i` is high that cycle; it re-sets on the next cycle if `irq_i` is still high.
- `irq_take = irq_pend & ~kernel & ~stall_i & ~br_valid_i & ~j_valid_i & ~jr_valid_i & ~exc_i`. An interrupt is deferred while any redirect is in flight, so the EPC is never lost.
- Priority, highest first, for selecting `nxt`:
  - `exc_i` → `XADR_VEC`; overrides `stall_i`.
  - `irq_take` → `ILLOP_VEC`.
  - `stall_i` → hold `pc_o`.
  - `jr_valid_i` → `jr_target_i`.
  - `j_valid_i` → `{pc_plus4_o[XLEN-1:28], j_index_i, 2'b00}`.
  - `br_valid_i & br_taken_i` → `br_target_i`.
  - Otherwise → `pc_plus4_o`.
- Not-taken branch (`br_valid_i & ~br_taken_i`): sequential, no flush.
- `redirect` = any of the following was selected: exc, irq, jr, j, or taken branch.
- Register updates each cycle:
  - `pc_o <= nxt`.
  - `flush_o <= redirect`.
  - `irq_ack_o <= irq_take`.
  - On exc: `epc_o <= pc_o`.
  - On irq: `epc_o <= pc_o` (next unfetched instruction).
  - Otherwise `epc_o` holds.
- Exceptions are taken in kernel mode too. `irq_pend` is retained while masked.
- Arithmetic: `pc_plus4_o` is modulo 2^XLEN, so `{XLEN{1'b1}}-3` wraps to 0. Targets are used unmodified: no alignment check and no kernel-bit forcing. JR to a user address leaves kernel mode.

## Timing
- Reset values: `pc_o=RESET_PC`, `flush_o=0`, `irq_ack_o=0`, `epc_o=0`, `irq_pend=0`.
- `reset` mid-redirect wins over all inputs. The next cycle shows `RESET_PC` with no flush.
- Redirect latency is 1 cycle: a request in cycle N produces `pc_o=target` and `flush_o=1` in cycle N+1.
- `flush_o` and `irq_ack_o` are 1-cycle pulses. Back-to-back redirects give consecutive pulses.
- `stall_i` with `jr/j/br` valid: redirect lost. The requester must hold its request until the stall drops (decode is frozen too).
- `irq_i` asserted in cycle N, unblocked: `irq_pend=1` in N+1, take in N+1, `pc_o=ILLOP_VEC` and `irq_ack_o=1` in N+2.

## Structure
- Package `pc_pkg`:
  - enum `pc_src_t` {SEQ, HOLD, BR, J, JR, IRQ, EXC}.
  - Default vector constants `RESET_PC`, `ILLOP_VEC`, `XADR_VEC`.
- Sub-module `pc_redirect_sel`: purely combinational priority encoder producing `pc_src_t` and `nxt`.
- Top level: `irq_pend`, the PC/EPC/pulse registers and the adder.

## Test plan
- Reset, then 3 free-running cycles → `pc_o` 8000_0000, 8000_0004, 8000_0008; `flush_o=0`.
- `pc_o`=0040_0010; `br_valid=1, br_taken=1, br_target`=0040_0100 → next `pc_o`=0040_0100, `flush_o=1`. Same with `br_taken=0` → 0040_0014, no flush.
- In the same cycle `jr_valid` (0040_0200), `j_valid` (index 0x0000_080) and taken branch → `pc_o`=0040_0200. With `exc_i` also high → 8000_0008, `epc_o`=old PC.
- User PC 0040_0020; pulse `irq_i` 1 cycle while `stall_i=1` for 2 cycles → no take during the stall. On release → `pc_o`=8000_0004, `irq_ack_o=1`, `epc_o`=0040_0020.
- `irq_i` high while PC=8000_0040 (kernel) → no take, `irq_pend` stays 1. After JR to 0040_0000 → taken the cycle after, `epc_o`=0040_0000.
- `pc_o`=FFFF_FFFC sequential → wraps to 0000_0000. `reset` asserted during a redirect → `pc_o`=8000_0000, `flush_o=0`.
